// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of a streaming FFT core: buffers an unthrottled
// sample stream, cuts it into NFFT-sample frames, emits a config word when the
// settings change, and watches the core's output stream for frame completion.
module fft_frame_ctrl #(
  parameter int unsigned NFFT    = 1024,
  parameter int unsigned LOG2N   = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SCALE_W = 10,
  parameter int unsigned CFG_W   = 16,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_en,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               fwd_inv,
  input  logic [SCALE_W-1:0] scale_sch,
  output logic               cfg_tvalid,
  output logic [CFG_W-1:0]   cfg_tdata,
  input  logic               cfg_tready,
  output logic               fft_tvalid,
  output logic               fft_tlast,
  output logic [DATA_W-1:0]  fft_tdata,
  input  logic               fft_tready,
  input  logic               m_tvalid,
  input  logic               m_tlast,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic               err_last,
  output logic               ovf,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned CUR_W = SCALE_W + 1;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NFFT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CFG    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CUR_W-1:0] cur_cfg;
  logic [CUR_W-1:0] last_cfg;
  logic             cfg_sent;
  logic [LOG2N-1:0] in_cnt;
  logic [LOG2N-1:0] out_cnt;

  logic             fifo_empty;
  logic             fifo_full;
  logic             in_stream;
  logic             pop;
  logic             push;
  logic             beat_last;
  logic             out_last;
  logic [CUR_W-1:0] new_cfg;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign in_stream  = (state == ST_STREAM);
  assign pop        = in_stream && !fifo_empty && fft_tready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push       = in_en && (!fifo_full || pop);
  assign beat_last  = pop && (in_cnt == LAST_IDX);
  assign out_last   = (out_cnt == LAST_IDX);
  assign new_cfg    = {scale_sch, fwd_inv};

  // Core-facing outputs are decoded from registered state only.
  assign cfg_tvalid = (state == ST_CFG);
  assign cfg_tdata  = CFG_W'(cur_cfg);
  assign fft_tvalid = in_stream && !fifo_empty;
  assign fft_tdata  = fft_tvalid ? mem[rd_ptr] : '0;
  assign fft_tlast  = in_stream && (in_cnt == LAST_IDX);
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // FIFO storage; no reset needed, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (in_en && !push) begin
        ovf <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: one IDLE cycle per frame, CFG only when settings changed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = (!cfg_sent || (new_cfg != last_cfg)) ? ST_CFG : ST_STREAM;
        end
      end
      ST_CFG: begin
        if (cfg_tready) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame settings capture, config bookkeeping and input sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_cfg  <= '0;
      last_cfg <= '0;
      cfg_sent <= 1'b0;
      in_cnt   <= '0;
    end else begin
      if ((state == ST_IDLE) && !fifo_empty) begin
        cur_cfg <= new_cfg;
      end
      if ((state == ST_CFG) && cfg_tready) begin
        last_cfg <= cur_cfg;
        cfg_sent <= 1'b1;
      end
      if (pop) begin
        in_cnt <= beat_last ? '0 : in_cnt + LOG2N'(1);
      end
    end
  end

  // Output-stream monitor; out_cnt free-runs and is never resynchronised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_last   <= 1'b0;
    end else begin
      frame_done <= m_tvalid && out_last;
      if (m_tvalid) begin
        out_cnt <= out_cnt + LOG2N'(1);
        if (out_last) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
        if (m_tlast != out_last) begin
          err_last <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a sample scoreboard on the core input.
module tb_fft_frame_ctrl;

  localparam int unsigned NFFT  = 1024;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic [31:0] in_data = '0;
  logic        fwd_inv = 1'b1;
  logic [9:0]  scale_sch = '0;
  logic        cfg_tvalid;
  logic [15:0] cfg_tdata;
  logic        cfg_tready = 1'b1;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic [31:0] fft_tdata;
  logic        fft_tready = 1'b1;
  logic        m_tvalid = 1'b0;
  logic        m_tlast = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_last;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Scoreboard / model state, owned by the monitor process.
  logic [31:0] exp_q [$];
  int          occ = 0;
  int          bcnt = 0;
  int          pops = 0;
  int          tlast_cnt = 0;
  int          cfg_cnt = 0;
  int          cfg_pop_idx = -1;
  int          drops = 0;
  logic [15:0] cfg_last = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  fft_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_data    (in_data),
    .fwd_inv    (fwd_inv),
    .scale_sch  (scale_sch),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tdata  (cfg_tdata),
    .cfg_tready (cfg_tready),
    .fft_tvalid (fft_tvalid),
    .fft_tlast  (fft_tlast),
    .fft_tdata  (fft_tdata),
    .fft_tready (fft_tready),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_last   (err_last),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: models the FIFO accept/drop rule and checks every core-side beat.
  initial forever begin
    logic        pop_b;
    logic [31:0] exp_d;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      occ = 0; bcnt = 0; pops = 0; tlast_cnt = 0;
      cfg_cnt = 0; cfg_pop_idx = -1; drops = 0; cfg_last = '0;
      prev_stall = 1'b0;
    end else begin
      pop_b = fft_tvalid && fft_tready;
      if (prev_stall) begin
        chk("stall_stable", {47'd0, fft_tvalid, fft_tdata}, {47'd0, 1'b1, prev_data});
      end
      prev_stall = fft_tvalid && !fft_tready;
      prev_data  = fft_tdata;
      if (cfg_tvalid && cfg_tready) begin
        cfg_cnt++;
        cfg_last    = cfg_tdata;
        cfg_pop_idx = pops;
      end
      if (pop_b) begin
        chk("pop_nonempty", 80'(exp_q.size() != 0), 80'(1));
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("fft_tdata", 80'(fft_tdata), 80'(exp_d));
        chk("fft_tlast", 80'(fft_tlast), 80'(bcnt == NFFT - 1));
        if (fft_tlast) tlast_cnt++;
        bcnt = (bcnt == NFFT - 1) ? 0 : bcnt + 1;
        pops++;
      end
      if (in_en) begin
        if ((occ < DEPTH) || pop_b) begin
          exp_q.push_back(in_data);
          occ++;
        end else begin
          drops++;
        end
      end
      if (pop_b) occ--;
    end
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; in_data = $urandom();
    end
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy !== 1'b0) && (n < 5000)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 80'(busy), 80'(0));
    chk({tag, "_empty"}, 80'(exp_q.size()), 80'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {9'd0, cfg_tvalid, cfg_tdata, fft_tvalid, fft_tlast, fft_tdata,
              frame_done, frame_cnt, err_last, ovf, busy}, 80'(0));
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_outputs");
    rst = 1'b0;

    // 1: one frame, fwd, scale 0
    send(NFFT);
    drain("t1_drain");
    chk("t1_cfg_cnt", 80'(cfg_cnt), 80'(1));
    chk("t1_cfg_data", 80'(cfg_last), 80'(16'h0001));
    chk("t1_cfg_before_data", 80'(cfg_pop_idx), 80'(0));
    chk("t1_tlast_cnt", 80'(tlast_cnt), 80'(1));
    chk("t1_pops", 80'(pops), 80'(NFFT));
    chk("t1_ovf", 80'(ovf), 80'(0));

    // 2: two frames, constant settings
    do_reset();
    send(2 * NFFT);
    drain("t2_drain");
    chk("t2_cfg_cnt", 80'(cfg_cnt), 80'(1));
    chk("t2_tlast_cnt", 80'(tlast_cnt), 80'(2));
    chk("t2_ovf", 80'(ovf), 80'(0));

    // 3: direction flip in the middle of a frame
    for (int i = 0; i < 2 * NFFT; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; in_data = $urandom();
      if (i == 500) fwd_inv = 1'b0;
    end
    @(posedge clk); #1 in_en = 1'b0;
    drain("t3_drain");
    chk("t3_cfg_cnt", 80'(cfg_cnt), 80'(2));
    chk("t3_cfg_data", 80'(cfg_last), 80'(16'h0000));
    chk("t3_cfg_at_frame2", 80'(cfg_pop_idx), 80'(3 * NFFT));
    chk("t3_tlast_cnt", 80'(tlast_cnt), 80'(4));

    // 5: output monitor, aligned frame then a misplaced tlast
    chk("t5_pre_err", 80'(err_last), 80'(0));
    chk("t5_pre_cnt", 80'(frame_cnt), 80'(0));
    for (int i = 0; i < NFFT; i++) begin
      @(posedge clk); #1;
      chk("t5_no_done_early", 80'(frame_done), 80'(0));
      m_tvalid = 1'b1; m_tlast = (i == NFFT - 1);
    end
    @(posedge clk); #1;
    m_tvalid = 1'b0; m_tlast = 1'b0;
    chk("t5_done", 80'(frame_done), 80'(1));
    chk("t5_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("t5_err_clean", 80'(err_last), 80'(0));
    @(posedge clk); #1;
    chk("t5_done_pulse", 80'(frame_done), 80'(0));
    for (int i = 0; i <= 500; i++) begin
      @(posedge clk); #1;
      m_tvalid = 1'b1; m_tlast = (i == 500);
    end
    @(posedge clk); #1;
    m_tvalid = 1'b0; m_tlast = 1'b0;
    chk("t5_err_set", 80'(err_last), 80'(1));
    repeat (5) @(posedge clk);
    #1 chk("t5_err_sticky", 80'(err_last), 80'(1));
    chk("t5_frame_cnt_hold", 80'(frame_cnt), 80'(1));

    // 4: 20-cycle stall while input keeps streaming
    fft_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; in_data = $urandom();
    end
    @(posedge clk); #1;
    fft_tready = 1'b1;
    in_en = 1'b1; in_data = $urandom();
    chk("t4_ovf", 80'(ovf), 80'(1));
    chk("t4_drop_range", 80'((drops >= 3) && (drops <= 5)), 80'(1));
    chk("t4_no_cfg", 80'(cfg_cnt), 80'(2));

    // 6: reset in the middle of a frame
    n = 0;
    while ((bcnt != 300) && (n < 3000)) begin
      @(posedge clk); #1;
      in_en = 1'b1; in_data = $urandom();
      n++;
    end
    chk("t6_reached_300", 80'(bcnt), 80'(300));
    rst = 1'b1; in_en = 1'b0;
    #1 chk_all_zero("t6_reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fwd_inv = 1'b1; scale_sch = 10'h2A5;
    send(NFFT);
    drain("t6_drain");
    chk("t6_cfg_cnt", 80'(cfg_cnt), 80'(1));
    chk("t6_cfg_data", 80'(cfg_last), 80'(16'h054B));
    chk("t6_cfg_before_data", 80'(cfg_pop_idx), 80'(0));
    chk("t6_tlast_cnt", 80'(tlast_cnt), 80'(1));
    chk("t6_pops", 80'(pops), 80'(NFFT));
    chk("t6_ovf", 80'(ovf), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
